// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32 ID/EX stage: ALU opcodes, operand selects,
// forwarding source select and the registered EX control word.
package rv32_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef enum logic [1:0] {
        ASEL_RS1   = 2'b00,
        ASEL_PC    = 2'b01,
        ASEL_ZERO  = 2'b10,
        ASEL_ZERO2 = 2'b11
    } asel_e;

    typedef enum logic {
        BSEL_RS2 = 1'b0,
        BSEL_IMM = 1'b1
    } bsel_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] alu_op;
        asel_e      asel;
        bsel_e      bsel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// Picks the forwarding source for one EX operand; EX/MEM beats MEM/WB and
// x0 is never forwarded.
module fwd_unit
    import rv32_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_reg_write,
    output fwd_sel_e   o_sel
);

    always_comb begin
        o_sel = FWD_NONE;
        if (i_rs != 5'd0) begin
            if (i_mem_reg_write && (i_mem_rd == i_rs))
                o_sel = FWD_MEM;
            else if (i_wb_reg_write && (i_wb_rd == i_rs))
                o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion
// and combinational EX/MEM and MEM/WB operand forwarding.
module id_ex_stage
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alu_op,
    input  logic [1:0]      id_asel,
    input  logic            id_bsel,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            flush,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [3:0]      ex_alu_op,
    output logic [31:0]     bubble_count
);

    ex_ctrl_t        r_ctrl;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [31:0]     r_bubble_count;

    logic            w_stall;
    logic            w_bubble;
    ex_ctrl_t        w_id_ctrl;
    fwd_sel_e        w_fwd1_sel;
    fwd_sel_e        w_fwd2_sel;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;

    // Load in EX whose destination is read by ID must wait one cycle.
    assign w_stall = id_valid && r_ctrl.valid && r_ctrl.mem_read && (r_ctrl.rd != 5'd0) &&
                     ((r_ctrl.rd == id_rs1) || (r_ctrl.rd == id_rs2));
    assign w_bubble = flush || w_stall || !id_valid;

    always_comb begin
        w_id_ctrl           = '0;
        w_id_ctrl.valid     = 1'b1;
        w_id_ctrl.reg_write = id_reg_write;
        w_id_ctrl.mem_read  = id_mem_read;
        w_id_ctrl.mem_write = id_mem_write;
        w_id_ctrl.alu_op    = id_alu_op;
        w_id_ctrl.asel      = asel_e'(id_asel);
        w_id_ctrl.bsel      = bsel_e'(id_bsel);
        w_id_ctrl.rd        = id_rd;
        w_id_ctrl.rs1       = id_rs1;
        w_id_ctrl.rs2       = id_rs2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
        end else if (w_bubble) begin
            r_ctrl     <= '0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
        end else begin
            r_ctrl     <= w_id_ctrl;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
        end
    end

    // Only load-use bubbles are counted; a flush overrides the stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bubble_count <= 32'd0;
        else if (w_stall && !flush)
            r_bubble_count <= r_bubble_count + 32'd1;
    end

    fwd_unit u_fwd_rs1 (
        .i_rs            (r_ctrl.rs1),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_sel           (w_fwd1_sel)
    );

    fwd_unit u_fwd_rs2 (
        .i_rs            (r_ctrl.rs2),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_sel           (w_fwd2_sel)
    );

    always_comb begin
        case (w_fwd1_sel)
            FWD_MEM: w_rs1_fwd = mem_result;
            FWD_WB:  w_rs1_fwd = wb_result;
            default: w_rs1_fwd = r_rs1_data;
        endcase
        case (w_fwd2_sel)
            FWD_MEM: w_rs2_fwd = mem_result;
            FWD_WB:  w_rs2_fwd = wb_result;
            default: w_rs2_fwd = r_rs2_data;
        endcase
    end

    always_comb begin
        case (r_ctrl.asel)
            ASEL_RS1: ex_a = w_rs1_fwd;
            ASEL_PC:  ex_a = r_pc;
            default:  ex_a = '0;
        endcase
        ex_b = (r_ctrl.bsel == BSEL_IMM) ? r_imm : w_rs2_fwd;
    end

    assign stall         = w_stall;
    assign ex_valid      = r_ctrl.valid;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_rd         = r_ctrl.rd;
    assign ex_alu_op     = r_ctrl.alu_op;
    assign ex_pc         = r_pc;
    assign ex_store_data = w_rs2_fwd;
    assign bubble_count  = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a behavioural model
// of the EX slot, its bubble counter and operand forwarding.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_asel;
    logic        id_bsel;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        stall;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_op;
    logic [31:0] bubble_count;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_asel(id_asel), .id_bsel(id_bsel), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
        .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_alu_op(ex_alu_op), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    // Reference model: contents of the EX slot as an abstract instruction record.
    logic        m_valid, m_rw, m_mr, m_mw;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [3:0]  m_alu;
    logic [1:0]  m_asel;
    logic        m_bsel;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm, m_bc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r != 0 && mem_reg_write && mem_rd == r) return mem_result;
        if (r != 0 && wb_reg_write && wb_rd == r)   return wb_result;
        return d;
    endfunction

    function automatic logic m_stall();
        return id_valid && m_valid && m_mr && m_rd != 0 && (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    task automatic m_clear();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
        m_alu = 0; m_asel = 0; m_bsel = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
    endtask

    task automatic model_edge();
        logic st;
        st = m_stall();
        if (flush || st || !id_valid) begin
            m_clear();
            if (st && !flush) m_bc = m_bc + 1;
        end else begin
            m_valid = 1; m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
            m_rd = id_rd; m_rs1 = id_rs1; m_rs2 = id_rs2; m_alu = id_alu_op;
            m_asel = id_asel; m_bsel = id_bsel; m_pc = id_pc;
            m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
        end
    endtask

    task automatic chk_out();
        logic [31:0] ea;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m_mw));
        chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        chk("ex_alu_op", 32'(ex_alu_op), 32'(m_alu));
        chk("bubble_count", bubble_count, m_bc);
        if (m_valid) begin
            ea = (m_asel == 2'b00) ? fwd(m_rs1, m_rs1d) : (m_asel == 2'b01) ? m_pc : 32'd0;
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_a", ex_a, ea);
            chk("ex_b", ex_b, m_bsel ? m_imm : fwd(m_rs2, m_rs2d));
            chk("ex_store_data", ex_store_data, fwd(m_rs2, m_rs2d));
        end
    endtask

    // Called at a falling edge with ID inputs already applied.
    task automatic step();
        #1 chk("stall", 32'(stall), 32'(m_stall()));
        @(posedge clk);
        model_edge();
        #1 chk_out();
        @(negedge clk);
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                          input logic [31:0] d2, input logic [4:0] rd, input logic mr);
        id_valid = 1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
        id_rd = rd; id_mem_read = mr; id_reg_write = 1; id_mem_write = 0;
        id_alu_op = 4'b0000; id_asel = 2'b00; id_bsel = 0; id_imm = 32'h100; id_pc = 32'h1000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0); id_valid = 0;
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
        m_clear(); m_bc = 0;
        @(negedge clk); @(negedge clk);
        #1 chk_out();
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_ex_a", ex_a, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Plain add.
        set_id(5'd1, 32'd5, 5'd2, 32'd7, 5'd9, 0);
        step();
        chk("add_ex_a", ex_a, 32'd5);
        chk("add_ex_b", ex_b, 32'd7);

        // Both forwarding sources target rs1: EX/MEM wins.
        set_id(5'd3, 32'h33, 5'd2, 32'd7, 5'd10, 0);
        step();
        mem_rd = 3; mem_reg_write = 1; mem_result = 32'h11;
        wb_rd = 3; wb_reg_write = 1; wb_result = 32'h22;
        #1 chk("dbl_ex_a", ex_a, 32'h11);
        chk_out();
        mem_rd = 9; #1 chk("wb_ex_a", ex_a, 32'h22);
        @(negedge clk);

        // x0 never forwarded.
        mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFF; wb_reg_write = 0;
        set_id(5'd0, 32'd0, 5'd0, 32'd0, 5'd11, 0);
        step();
        chk("x0_ex_a", ex_a, 32'd0);
        mem_reg_write = 0;

        // Load-use: lw x4 then add reading x4.
        set_id(5'd1, 32'd8, 5'd2, 32'd0, 5'd4, 1);
        step();
        set_id(5'd4, 32'd0, 5'd5, 32'd3, 5'd6, 0);
        #1 chk("lu_stall", 32'(stall), 32'd1);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_count", bubble_count, 32'd1);
        step();
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rd", 32'(ex_rd), 32'd6);

        // Flush coinciding with a load-use stall.
        set_id(5'd1, 32'd8, 5'd2, 32'd0, 5'd4, 1);
        step();
        set_id(5'd4, 32'd0, 5'd5, 32'd3, 5'd6, 0);
        flush = 1;
        #1 chk("fs_stall", 32'(stall), 32'd1);
        step();
        flush = 0;
        chk("fs_valid", 32'(ex_valid), 32'd0);
        chk("fs_bubble_count", bubble_count, 32'd1);

        // Randomized traffic with a small register space to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            id_valid = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 9) == 0);
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
            id_alu_op = 4'($urandom_range(0, 15)); id_asel = 2'($urandom_range(0, 3));
            id_bsel = 1'($urandom_range(0, 1));
            id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
            id_mem_write = 1'($urandom_range(0, 1));
            mem_rd = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom_range(0, 1));
            mem_result = $urandom;
            wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom_range(0, 1));
            wb_result = $urandom;
            step();
        end
        flush = 0;

        // Asynchronous reset mid-stream with a valid instruction in EX.
        set_id(5'd1, 32'hABC, 5'd2, 32'hDEF, 5'd7, 0);
        mem_reg_write = 0; wb_reg_write = 0;
        step();
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2 rst_n = 0;
        #1 m_clear(); m_bc = 0;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_a", ex_a, 32'd0);
        chk("rst_ex_b", ex_b, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_bc", bubble_count, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 chk("rst_hold_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        rst_n = 1;
        step();
        chk("post_rst_capture", 32'(ex_valid), 32'd1);
        chk("post_rst_ex_a", ex_a, 32'hABC);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
